// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame transmitter and the future receiver:
//   - parity-mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD / PAR_MARK)
//   - one-hot frame state encodings
//   - default bit period in clocks
//   - parity helper function
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // Widest payload supported; the parity helper works on a zero-padded word.
  localparam int MAX_DATA_BITS = 9;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_BREAK  = 6'b100000
  } uart_state_e;

  // Parity bit for a payload. Unused upper bits must be zero so the XOR
  // reduction only sees real data bits.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0]               mode);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Bit-period counter shared by the UART transmitter and receiver. Counts
// 0..CLKS_PER_BIT-1 and wraps; a restart forces the next count to 0 so a new
// state always begins with a full bit period.
// Ports:
//   i_clk          system clock (rising edge)
//   i_rst_n        asynchronous active-low reset
//   i_restart      restart the bit period on the next clock
//   o_bit_end      high on the last clock of a bit period
//   o_bit_pre_end  high on the clock before the last one (lets the user
//                  register outputs that must line up with o_bit_end)
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_bit_pre_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_bit_end     = (cnt_q == CNT_LAST);
  assign o_bit_pre_end = (cnt_q == CNT_PRE);

  // Next count: restart or wrap to zero, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (i_restart) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (o_bit_end) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter with configurable data width, runtime parity / stop-bit
// selection, valid/ready input handshake and line-break generation.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_tx_valid       i_tx_data holds a frame payload
//   i_tx_data        payload, sent LSB first
//   o_tx_ready       frame accepted this cycle if i_tx_valid (IDLE, no break)
//   i_parity_mode    00 none, 01 even, 10 odd, 11 mark
//   i_two_stop       0 one stop bit, 1 two stop bits
//   i_break          request a line break (honoured only from IDLE)
//   o_tx             serial line, idle high (registered)
//   o_tx_busy        frame or break in progress (registered)
//   o_tx_done        one-cycle pulse on the last stop cycle (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  input  logic                 i_break,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int BRK_W = $clog2(DATA_BITS + 4);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  // A break lasts at least one full frame worth of bit periods.
  localparam logic [BRK_W-1:0] BRK_MIN    = BRK_W'(DATA_BITS + 3);
  localparam logic [BRK_W-1:0] BRK_MIN_M1 = BRK_W'(DATA_BITS + 2);

  uart_state_e              state_q, state_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DATA_BITS-1:0]     data_q, data_d;
  logic [1:0]               mode_q, mode_d;
  logic                     two_q, two_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     stop_last_q, stop_last_d;
  logic [BRK_W-1:0]         brk_cnt_q, brk_cnt_d;

  logic                     tx_ready_s;
  logic                     bit_end_s;
  logic                     bit_pre_end_s;
  logic                     restart_s;
  logic                     brk_met_s;
  logic                     par_bit_s;
  logic [MAX_DATA_BITS-1:0] par_in_s;

  // Ready is forced low while reset is asserted even though the state
  // register already reads IDLE.
  assign tx_ready_s = (state_q == ST_IDLE) && !i_break;
  assign o_tx_ready = tx_ready_s && i_rst_n;

  assign o_tx      = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

  // Every state change starts a fresh bit period.
  assign restart_s = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_restart     (restart_s),
    .o_bit_end     (bit_end_s),
    .o_bit_pre_end (bit_pre_end_s)
  );

  // Zero-pad the latched payload for the shared parity helper.
  always_comb begin
    par_in_s                = {MAX_DATA_BITS{1'b0}};
    par_in_s[DATA_BITS-1:0] = data_q;
    par_bit_s               = parity_bit(par_in_s, mode_q);
  end

  // Break minimum is met once the counted bit periods reach the limit,
  // including the period that is ending this cycle.
  assign brk_met_s = (brk_cnt_q == BRK_MIN) ||
                     (bit_end_s && (brk_cnt_q == BRK_MIN_M1));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    two_d       = two_q;
    idx_d       = idx_q;
    stop_last_d = stop_last_q;
    brk_cnt_d   = brk_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Break wins over a pending frame.
        if (i_break) begin
          state_d   = ST_BREAK;
          brk_cnt_d = {BRK_W{1'b0}};
        end else if (i_tx_valid && tx_ready_s) begin
          state_d = ST_START;
          data_d  = i_tx_data;
          mode_d  = i_parity_mode;
          two_d   = i_two_stop;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (idx_q == IDX_LAST)) begin
          if (mode_q != PAR_NONE) begin
            state_d = ST_PARITY;
          end else begin
            state_d     = ST_STOP;
            stop_last_d = ~two_q;
          end
        end else if (bit_end_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d     = ST_STOP;
          stop_last_d = ~two_q;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s && stop_last_q) begin
          state_d = ST_IDLE;
        end else if (bit_end_s) begin
          stop_last_d = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (bit_end_s && (brk_cnt_q != BRK_MIN)) begin
          brk_cnt_d = brk_cnt_q + BRK_W'(1);
        end else begin
          brk_cnt_d = brk_cnt_q;
        end
        // A break always closes with exactly one stop bit.
        if (brk_met_s && !i_break) begin
          state_d     = ST_STOP;
          stop_last_d = 1'b1;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so o_tx is a plain flop.
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[idx_d];
      ST_PARITY: tx_d = par_bit_s;
      ST_STOP:   tx_d = 1'b1;
      ST_BREAK:  tx_d = 1'b0;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    // Registered one cycle early so the pulse coincides with the last stop
    // clock.
    done_d = (state_q == ST_STOP) && stop_last_q && bit_pre_end_s;
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= {DATA_BITS{1'b0}};
      mode_q      <= PAR_NONE;
      two_q       <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      stop_last_q <= 1'b0;
      brk_cnt_q   <= {BRK_W{1'b0}};
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      two_q       <= two_d;
      idx_q       <= idx_d;
      stop_last_q <= stop_last_d;
      brk_cnt_q   <= brk_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Scoreboard bench for uart_tx_frame. Three DUTs (8, 7 and 9 data bits, four
// clocks per bit). Stimulus pushes the hand-computed serial frame (or break
// length) into a queue; a monitor records o_tx while busy and compares on
// every o_tx_done pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;   // serial bits, index 0 = start bit
    int          nbits;  // 0 marks a break entry
    int          lo;     // expected low cycles of a break
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid_v, brk_v, tx_v, busy_v, done_v, ready_v;
  logic [7:0] data8;
  logic [6:0] data7;
  logic [8:0] data9;
  logic [1:0] par_mode;
  logic       two_stop;

  exp_t exp_q[$];
  logic line_q[$];
  int   sel;
  int   n_checks;
  int   n_errors;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(valid_v[0]), .i_tx_data(data8),
    .o_tx_ready(ready_v[0]), .i_parity_mode(par_mode), .i_two_stop(two_stop),
    .i_break(brk_v[0]), .o_tx(tx_v[0]), .o_tx_busy(busy_v[0]), .o_tx_done(done_v[0]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7)) u_dut7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(valid_v[1]), .i_tx_data(data7),
    .o_tx_ready(ready_v[1]), .i_parity_mode(par_mode), .i_two_stop(two_stop),
    .i_break(brk_v[1]), .o_tx(tx_v[1]), .o_tx_busy(busy_v[1]), .o_tx_done(done_v[1]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(9)) u_dut9 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(valid_v[2]), .i_tx_data(data9),
    .o_tx_ready(ready_v[2]), .i_parity_mode(par_mode), .i_two_stop(two_stop),
    .i_break(brk_v[2]), .o_tx(tx_v[2]), .o_tx_busy(busy_v[2]), .o_tx_done(done_v[2]));

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Records the selected DUT's line while busy; compares on each done pulse.
  task automatic monitor();
    exp_t        e;
    logic [15:0] got;
    int          stable;
    int          lows;
    int          tail_ok;
    forever begin
      @(negedge clk);
      if (busy_v[sel] !== 1'b1) line_q.delete();
      else line_q.push_back(tx_v[sel]);
      if (done_v[sel] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.nbits > 0) begin
            check("frame_len", line_q.size(), e.nbits * CPB);
            got = 16'h0000;
            stable = 1;
            for (int i = 0; i < line_q.size(); i++) begin
              if (i / CPB < 16) begin
                if (i % CPB == 0) got[i / CPB] = line_q[i];
                else if (line_q[i] !== got[i / CPB]) stable = 0;
              end
            end
            check("frame_bits", int'(got), int'(e.bits));
            check("frame_bit_stable", stable, 1);
          end else begin
            lows = 0;
            while (lows < line_q.size() && line_q[lows] === 1'b0) lows++;
            tail_ok = 1;
            for (int i = lows; i < line_q.size(); i++)
              if (line_q[i] !== 1'b1) tail_ok = 0;
            check("brk_low_cycles", lows, e.lo);
            check("brk_stop_cycles", line_q.size() - lows, CPB);
            check("brk_stop_high", tail_ok, 1);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_v[d] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy_v[d]), 0);
    @(negedge clk);
  endtask

  task automatic send(input int d, input logic [8:0] data, input logic [15:0] bits,
                      input int nbits);
    exp_t e;
    int   n;
    e.bits = bits; e.nbits = nbits; e.lo = 0;
    sel = d;
    n = 0;
    @(negedge clk);
    while (ready_v[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(ready_v[d]), 1);
    exp_q.push_back(e);
    case (d)
      0:       data8 = data[7:0];
      1:       data7 = data[6:0];
      default: data9 = data;
    endcase
    valid_v[d] = 1'b1;
    @(posedge clk);
    #1 valid_v[d] = 1'b0;
    @(negedge clk);
    check("start_bit_latency", int'(tx_v[d]), 0);
    check("busy_after_accept", int'(busy_v[d]), 1);
    wait_idle(d);
  endtask

  task automatic do_break(input int hold, input int lo, input logic with_valid);
    exp_t e;
    e.bits = 16'h0000; e.nbits = 0; e.lo = lo;
    sel = 0;
    exp_q.push_back(e);
    @(negedge clk);
    brk_v[0] = 1'b1;
    data8 = 8'h5A;
    valid_v[0] = with_valid;
    #1 check("ready_low_on_break", int'(ready_v[0]), 0);
    repeat (hold) @(negedge clk);
    brk_v[0] = 1'b0;
    valid_v[0] = 1'b0;
    wait_idle(0);
  endtask

  initial begin
    int nready, dones, after_done, word, n;
    n_checks = 0; n_errors = 0; sel = 0;
    rst_n = 1'b0; valid_v = 3'b000; brk_v = 3'b000;
    data8 = 8'h00; data7 = 7'h00; data9 = 9'h000;
    par_mode = 2'b00; two_stop = 1'b0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx_v[0]), 1);
    check("rst_ready", int'(ready_v[0]), 0);
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    rst_n = 1'b1;
    #1 check("ready_after_release", int'(ready_v[0]), 1);

    // 8N1 0xA5
    send(0, 9'h0A5, 16'b1101001010, 10);
    // 7 data bits 0x55, even then odd parity
    par_mode = 2'b01;
    send(1, 9'h055, 16'b1010101010, 10);
    par_mode = 2'b10;
    send(1, 9'h055, 16'b1110101010, 10);
    // 9 data bits 0x1FF, mark parity, two stop bits
    par_mode = 2'b11; two_stop = 1'b1;
    send(2, 9'h1FF, 16'b1111111111110, 13);
    par_mode = 2'b00; two_stop = 1'b0;

    // Back-to-back frames with valid held high
    begin
      exp_t e;
      e.nbits = 10; e.lo = 0;
      e.bits = 16'b1000000010; exp_q.push_back(e);
      e.bits = 16'b1000000100; exp_q.push_back(e);
      e.bits = 16'b1000000110; exp_q.push_back(e);
    end
    sel = 0;
    @(negedge clk);
    data8 = 8'h01; valid_v[0] = 1'b1;
    nready = 0; dones = 0; after_done = 0; word = 0; n = 0;
    while (dones < 3 && n < 300) begin
      if (n > 0) @(negedge clk);
      n++;
      if (after_done == 1) check("b2b_gap_idle", int'({busy_v[0], ready_v[0], tx_v[0]}), 3);
      if (after_done == 2) check("b2b_next_start", int'({busy_v[0], tx_v[0]}), 2);
      if (done_v[0] === 1'b1) begin
        dones++;
        after_done = 1;
      end else if (after_done > 0) begin
        after_done++;
      end
      if (ready_v[0] === 1'b1 && dones < 3) begin
        nready++;
        @(posedge clk);
        #1;
        word++;
        if (word == 1) data8 = 8'h02;
        else if (word == 2) data8 = 8'h03;
        else valid_v[0] = 1'b0;
      end
    end
    check("b2b_done_count", dones, 3);
    check("b2b_ready_cycles", nready, 3);
    valid_v[0] = 1'b0;
    wait_idle(0);

    // Break: 2-cycle pulse with valid also high, then held for 100 cycles
    do_break(2, (8 + 3) * CPB, 1'b1);
    do_break(100, 100, 1'b0);

    // Break requested mid-frame is ignored; frame completes intact
    fork
      send(0, 9'h03C, 16'b1001111000, 10);
      begin
        repeat (10) @(negedge clk);
        brk_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        brk_v[0] = 1'b0;
      end
    join

    // Reset in the middle of the data bits
    sel = 0;
    @(negedge clk);
    data8 = 8'hFF; valid_v[0] = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_before_reset", int'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx_v[0]), 1);
    check("midrst_busy", int'(busy_v[0]), 0);
    check("midrst_done", int'(done_v[0]), 0);
    check("midrst_ready", int'(ready_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_midrst", int'(ready_v[0]), 1);
    send(0, 9'h03C, 16'b1001111000, 10);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
